// File: rtl/fan_adc_sampler.sv
// Fan controller front end: synchronises the ADC/setpoint/config inputs, samples the ADC
// on a fixed tick and emits a rounded average of 2^AVG_LOG2 samples with a one-cycle strobe.
module fan_adc_sampler #(
    parameter int ADC_BITWIDTH = 4,
    parameter int AVG_LOG2     = 2,
    parameter int TICK_DIV     = 100000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic [ADC_BITWIDTH-1:0] ADC_raw_i,
    input  logic [ADC_BITWIDTH-1:0] SET_raw_i,
    input  logic                    config_en_raw_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic [ADC_BITWIDTH-1:0] SET_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    config_en_o,
    output logic                    tick_o
);
    localparam int W  = ADC_BITWIDTH;
    localparam int AW = W + AVG_LOG2 + 1;
    localparam int SW = 2 * W + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [AW-1:0]       HALF      = AW'(2 ** (AVG_LOG2 - 1));

    typedef enum logic [1:0] {ACCUM, EMIT, CONFIG} state_t;

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic [W-1:0]                   adc_s;
    logic [W-1:0]                   set_s;
    logic                           cfg_s;

    logic [TW-1:0]       tick_cnt_q;
    logic                tick;

    state_t              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [W-1:0]        adc_value_q, adc_value_d;
    logic [W-1:0]        set_value_q, set_value_d;
    logic                strobe;

    logic [AW-1:0]       sample;
    logic [AW-1:0]       rounded;
    logic [AW-1:0]       shifted;
    logic [W-1:0]        avg;

    // Synchronisers are deliberately not gated by clk_en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {config_en_raw_i, SET_raw_i, ADC_raw_i}};
        end
    end

    assign adc_s = sync_q[SYNC_STAGES-1][W-1:0];
    assign set_s = sync_q[SYNC_STAGES-1][2*W-1:W];
    assign cfg_s = sync_q[SYNC_STAGES-1][2*W];

    assign tick = clk_en_i && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
        end else if (clk_en_i) begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    assign sample  = {{(AW - W){1'b0}}, adc_s};
    assign rounded = acc_q + HALF;
    assign shifted = rounded >> AVG_LOG2;
    assign avg     = (|shifted[AW-1:W]) ? '1 : shifted[W-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        adc_value_d = adc_value_q;
        set_value_d = set_value_q;
        strobe      = 1'b0;
        if (clk_en_i) begin
            // Config has priority over everything, including a pending emit.
            if (cfg_s) begin
                state_d     = CONFIG;
                acc_d       = '0;
                cnt_d       = '0;
                set_value_d = set_s;
            end else begin
                unique case (state_q)
                    CONFIG: begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                    ACCUM: begin
                        if (tick) begin
                            acc_d = acc_q + sample;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                state_d = EMIT;
                            end
                        end
                    end
                    EMIT: begin
                        strobe      = 1'b1;
                        adc_value_d = avg;
                        state_d     = ACCUM;
                        acc_d       = tick ? sample : '0;
                        cnt_d       = tick ? AVG_LOG2'(1) : '0;
                    end
                    default: begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            adc_value_q <= '0;
            set_value_q <= '0;
        end else if (clk_en_i) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            adc_value_q <= adc_value_d;
            set_value_q <= set_value_d;
        end
    end

    // The new average is presented during the strobe cycle itself, then held.
    assign ADC_value_o      = strobe ? avg : adc_value_q;
    assign SET_value_o      = set_value_q;
    assign dataVaild_STRB_o = strobe;
    assign config_en_o      = cfg_s;
    assign tick_o           = tick;

endmodule

// File: tb/tb_fan_adc_sampler.sv
// Directed bench for fan_adc_sampler: expected averages are queued per window and
// compared when the strobe fires; timing, config, clock-enable and reset cases are checked inline.
module tb_fan_adc_sampler;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clk_en_i = 1'b1;
    logic [3:0] ADC_raw_i = '0;
    logic [3:0] SET_raw_i = '0;
    logic       config_en_raw_i = 1'b0;
    logic [3:0] ADC_value_o;
    logic [3:0] SET_value_o;
    logic       dataVaild_STRB_o;
    logic       config_en_o;
    logic       tick_o;

    int errors = 0;
    int checks = 0;
    int strb_cnt = 0;
    int last_adc = 0;
    bit tgl = 1'b0;
    bit prev_strb = 1'b0;
    int sbq[$];

    fan_adc_sampler #(
        .ADC_BITWIDTH(4),
        .AVG_LOG2(2),
        .TICK_DIV(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clk_en_i(clk_en_i),
        .ADC_raw_i(ADC_raw_i),
        .SET_raw_i(SET_raw_i),
        .config_en_raw_i(config_en_raw_i),
        .ADC_value_o(ADC_value_o),
        .SET_value_o(SET_value_o),
        .dataVaild_STRB_o(dataVaild_STRB_o),
        .config_en_o(config_en_o),
        .tick_o(tick_o)
    );

    always #5 clk_i = ~clk_i;

    // Clock-enable toggler, kept clear of both clock edges.
    always @(posedge clk_i) if (tgl) #2 clk_en_i = ~clk_en_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest pending window.
    always @(negedge clk_i) begin
        if (dataVaild_STRB_o) begin
            strb_cnt++;
            check("strobe_width", int'(prev_strb), 0);
            check("sb_pending", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) check("adc_avg", int'(ADC_value_o), sbq.pop_front());
        end
        prev_strb = dataVaild_STRB_o;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_tick(output int t);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!tick_o && n < 200);
        if (!tick_o) check("tick_timeout", int'(tick_o), 1);
        t = int'($time);
    endtask

    // One full averaging window: four ticks, then the strobe after dly cycles.
    task automatic run_window(input int s0, input int s1, input int s2, input int s3,
                              input int period, input int dly);
        int s[4];
        int t, t_prev, sum, exp, sc0;
        s = '{s0, s1, s2, s3};
        sum = s0 + s1 + s2 + s3;
        exp = (sum + 2) >> 2;
        if (exp > 15) exp = 15;
        sbq.push_back(exp);
        sc0 = strb_cnt;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            ADC_raw_i = 4'(s[k]);
            wait_tick(t);
            if (k > 0) check("tick_period", t - t_prev, period);
            t_prev = t;
        end
        check("no_early_strobe", strb_cnt, sc0);
        check("adc_hold", int'(ADC_value_o), last_adc);
        for (int d = 1; d <= dly; d++) begin
            @(negedge clk_i);
            check("strobe_timing", int'(dataVaild_STRB_o), int'(d == dly));
        end
        @(negedge clk_i);
        check("strobe_low_after", int'(dataVaild_STRB_o), 0);
        check("adc_held_after", int'(ADC_value_o), exp);
        last_adc = exp;
    endtask

    initial begin
        int t, sc;
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_adc", int'(ADC_value_o), 0);
        check("rst_set", int'(SET_value_o), 0);
        check("rst_strobe", int'(dataVaild_STRB_o), 0);
        check("rst_cfg", int'(config_en_o), 0);
        check("rst_tick", int'(tick_o), 0);
        rst_i = 1'b0;

        run_window(7, 7, 7, 7, 40, 1);
        run_window(1, 2, 2, 2, 40, 1);
        run_window(15, 15, 15, 15, 40, 1);
        run_window(1, 1, 1, 2, 40, 1);

        // Setpoint only moves in config mode.
        SET_raw_i = 4'd9;
        repeat (5) @(negedge clk_i);
        check("set_frozen_pre", int'(SET_value_o), 0);
        check("cfg_low_pre", int'(config_en_o), 0);
        sc = strb_cnt;
        config_en_raw_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("set_in_cfg", int'(SET_value_o), 9);
        check("cfg_high", int'(config_en_o), 1);
        repeat (7) @(negedge clk_i);
        wait_tick(t);
        config_en_raw_i = 1'b0;
        check("cfg_no_strobe", strb_cnt, sc);
        SET_raw_i = 4'd3;
        run_window(3, 4, 5, 6, 40, 1);
        check("set_frozen_post", int'(SET_value_o), 9);
        check("cfg_low_post", int'(config_en_o), 0);

        // Config pulse mid-window discards the partial samples.
        sc = strb_cnt;
        ADC_raw_i = 4'd8;
        wait_tick(t);
        wait_tick(t);
        config_en_raw_i = 1'b1;
        repeat (3) @(negedge clk_i);
        config_en_raw_i = 1'b0;
        wait_tick(t);
        check("abort_no_strobe", strb_cnt, sc);
        run_window(10, 10, 10, 11, 40, 1);
        check("set_after_abort", int'(SET_value_o), 3);

        // Clock enable toggling every cycle halves the tick rate.
        tgl = 1'b1;
        run_window(6, 6, 6, 6, 80, 2);
        tgl = 1'b0;
        clk_en_i = 1'b1;

        // Asynchronous reset between clock edges, mid-window.
        ADC_raw_i = 4'd9;
        wait_tick(t);
        wait_tick(t);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("arst_adc", int'(ADC_value_o), 0);
        check("arst_set", int'(SET_value_o), 0);
        check("arst_strobe", int'(dataVaild_STRB_o), 0);
        check("arst_cfg", int'(config_en_o), 0);
        check("arst_tick", int'(tick_o), 0);
        sbq.delete();
        last_adc = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_window(12, 13, 12, 13, 40, 1);

        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fan_adc_sampler.md
Name: fan_adc_sampler

Overview:
- Upstream front end of the fan controller.
- Synchronises the raw ADC and setpoint nibbles and the config switch, samples the ADC on a fixed time base, and averages 2^AVG_LOG2 samples.
- Emits a one-cycle dataVaild_STRB with the averaged ADC value and the latched setpoint, which the PID/PWM stage consumes directly.

Parameters:
- ADC_BITWIDTH, 4, width of ADC and setpoint values.
- AVG_LOG2, 2, log2 of samples averaged per strobe (1..4).
- TICK_DIV, 100000, enabled clock cycles per sample tick (10 ms at 10 MHz).
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (>=2).

Ports:
- clk_i  in  1  system clock, 10 MHz.
- rst_i  in  1  asynchronous active-high reset.
- clk_en_i  in  1  clock enable; tick counter, accumulator, FSM and register updates advance only when high. Synchronisers run every clock.
- ADC_raw_i  in  ADC_BITWIDTH  asynchronous ADC sample.
- SET_raw_i  in  ADC_BITWIDTH  asynchronous setpoint switches.
- config_en_raw_i  in  1  asynchronous config-mode switch.
- ADC_value_o  out  ADC_BITWIDTH  averaged ADC value, held between strobes.
- SET_value_o  out  ADC_BITWIDTH  latched setpoint.
- dataVaild_STRB_o  out  1  one-cycle pulse: new ADC_value_o/SET_value_o valid.
- config_en_o  out  1  synchronised config mode.
- tick_o  out  1  one-cycle pulse per sample tick (debug/bench).

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs 0, sync chains 0, tick counter 0, accumulator 0, sample counter 0, FSM = ACCUM.
- Synchronisers: all raw inputs pass through SYNC_STAGES flops. Internal logic uses only the synchronised values (adc_s, set_s, cfg_s).
- config_en_o = cfg_s.
- Tick counter: counts 0..TICK_DIV-1 on enabled cycles. tick_o = 1 on the enabled cycle where the count equals TICK_DIV-1; the count then wraps to 0. Never stalls in any state.
- FSM states:
  - CONFIG: entered from any state on the cycle cfg_s = 1.
    - Accumulator and sample counter cleared each enabled cycle; no strobe.
    - SET_value_o <= set_s every enabled cycle.
    - On cfg_s = 0: go to ACCUM.
  - ACCUM: on tick, acc <= acc + adc_s and cnt <= cnt + 1. When that sample is number 2^AVG_LOG2 (cnt == 2^AVG_LOG2-1 before the increment), go to EMIT.
  - EMIT: one enabled cycle.
    - ADC_value_o <= (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, round half up, saturated to 2^ADC_BITWIDTH-1.
    - dataVaild_STRB_o = 1 for exactly this cycle.
    - acc, cnt cleared; go to ACCUM.
    - A tick arriving in EMIT is not lost: its sample is added as the first sample of the next window.
- Accumulator width ADC_BITWIDTH+AVG_LOG2+1, unsigned; no overflow possible.
- Strobe is a single clk_i cycle wide even if clk_en_i stays high. If clk_en_i is low, EMIT holds and the strobe is asserted only on the enabled cycle.
- cfg_s rising mid-window discards the partial window; no strobe until a full window completes after config exits.
- SET_value_o changes only in CONFIG. Outside config it stays frozen against switch bounce.
- Simultaneous cfg_s rise and EMIT: CONFIG wins; the strobe is suppressed and ADC_value_o is not updated.
- Reset mid-window: everything returns to reset values immediately. The first strobe after reset needs a full 2^AVG_LOG2 ticks.
- Latency: ADC_raw_i change to visible adc_s is SYNC_STAGES cycles. Last tick of a window to strobe is 1 enabled cycle.

Test Plan:
- Bench uses TICK_DIV=4, AVG_LOG2=2, clk_en_i=1.
- Reset release, ADC_raw_i=4'd7 constant -> tick_o every 4 cycles; first dataVaild_STRB_o 1 cycle after the 4th tick, ADC_value_o=7, width exactly 1 cycle; all outputs 0 before it.
- Samples 1,2,2,2 (sum 7) -> ADC_value_o=2 (7+2=9>>2). Samples 15,15,15,15 -> 15, no overflow. Samples 1,1,1,2 -> 1.
- SET_raw_i=9 with config_en_raw_i=0 -> SET_value_o stays 0. Raise config 10 cycles -> SET_value_o=9 within SYNC_STAGES+1 cycles, config_en_o=1, no strobe. Drop config -> next strobe 4 ticks later.
- Raise config after 2 ticks of a window, release after 3 cycles -> no strobe for that window; next strobe needs 4 fresh ticks.
- clk_en_i toggling 1/0 each cycle -> tick period doubles to 8 clk_i cycles; strobe still exactly 1 clk_i cycle wide.
- Assert rst_i asynchronously mid-window between clock edges -> outputs 0 immediately; first strobe only after 4 new ticks.
